logic_unit_pipe: RTL

//  Parametrised, pipelined successor to the 5-bit AND cell: bitwise logic unit for the CPU datapath.

---
 rtl/logic_pkg.sv | 30 +++
 rtl/logic_unit_comb.sv | 35 +++
 rtl/logic_unit_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit: opcode encoding and flag bit layout.
package logic_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 3;

   localparam int unsigned FLAG_CF = 2;
   localparam int unsigned FLAG_SF = 1;
   localparam int unsigned FLAG_ZF = 0;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

   function automatic logic [FLAG_W-1:0] pack_flags(input logic cf, input logic sf,
                                                    input logic zf);
      logic [FLAG_W-1:0] f;
      f          = '0;
      f[FLAG_CF] = cf;
      f[FLAG_SF] = sf;
      f[FLAG_ZF] = zf;
      return f;
   endfunction

endpackage

// File: rtl/logic_unit_comb.sv
// Combinational op mux and per-result flag generation for the logic unit.
module logic_unit_comb
   import logic_pkg::*;
#(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [OP_W-1:0]  op_i,
   output logic [WIDTH-1:0] z_o,
   output logic             cf_o,
   output logic             sf_o,
   output logic             zf_o
);

   always_comb begin
      z_o = '0;
      unique case (op_i)
         OP_AND:  z_o = a_i & b_i;
         OP_OR:   z_o = a_i | b_i;
         OP_XOR:  z_o = a_i ^ b_i;
         OP_NAND: z_o = ~(a_i & b_i);
         OP_NOR:  z_o = ~(a_i | b_i);
         OP_XNOR: z_o = ~(a_i ^ b_i);
         OP_NOT:  z_o = ~a_i;
         OP_PASS: z_o = a_i;
      endcase
   end

   // Carry has no meaning for logic ops; the port mirrors the arithmetic unit.
   assign cf_o = 1'b0;
   assign sf_o = z_o[WIDTH-1];
   assign zf_o = (z_o == '0);

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes and a flag register.
module logic_unit_pipe
   import logic_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned OPW   = OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [OPW-1:0]    op,
   input  logic              flag_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  z,
   output logic              cf,
   output logic              sf,
   output logic              zf,
   output logic [FLAG_W-1:0] flags_q
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [OPW-1:0]   s1_op_q, s1_op_d;
   logic             s1_we_q, s1_we_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             cf_q, cf_d;
   logic             sf_q, sf_d;
   logic             zf_q, zf_d;
   logic             s2_we_q, s2_we_d;

   logic [FLAG_W-1:0] flags_d;

   logic [WIDTH-1:0] c_z;
   logic             c_cf, c_sf, c_zf;
   logic             s2_adv, in_fire, out_fire;

   logic_unit_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .a_i  (s1_a_q),
      .b_i  (s1_b_q),
      .op_i (s1_op_q),
      .z_o  (c_z),
      .cf_o (c_cf),
      .sf_o (c_sf),
      .zf_o (c_zf)
   );

   // No skid buffer: S1 can only accept when it is empty or draining into S2.
   assign s2_adv   = ~out_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | s2_adv;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      s1_we_d     = s1_we_q;
      out_valid_d = out_valid_q;
      z_d         = z_q;
      cf_d        = cf_q;
      sf_d        = sf_q;
      zf_d        = zf_q;
      s2_we_d     = s2_we_q;
      flags_d     = flags_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = a;
         s1_b_d     = b;
         s1_op_d    = op;
         s1_we_d    = flag_we;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      // On a bubble S2 keeps its last result; only out_valid drops.
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            z_d     = c_z;
            cf_d    = c_cf;
            sf_d    = c_sf;
            zf_d    = c_zf;
            s2_we_d = s1_we_q;
         end
      end

      if (out_fire && s2_we_q) begin
         flags_d = pack_flags(cf_q, sf_q, zf_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         s1_we_q     <= 1'b0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
         cf_q        <= 1'b0;
         sf_q        <= 1'b0;
         zf_q        <= 1'b0;
         s2_we_q     <= 1'b0;
         flags_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         s1_we_q     <= s1_we_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         cf_q        <= cf_d;
         sf_q        <= sf_d;
         zf_q        <= zf_d;
         s2_we_q     <= s2_we_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign cf        = cf_q;
   assign sf        = sf_q;
   assign zf        = zf_q;

endmodule
